// File: rtl/display_pkg.sv
// Shared constants, FSM state encoding and the hex-to-segment table for the
// 7-segment output display driver.
package display_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    typedef enum logic {
        BLANK = 1'b0,
        SCAN  = 1'b1
    } state_e;

    // Active-low pattern, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/display_if.sv
// Bus between the processor write-back Output port and the display driver.
interface display_if;
    logic [15:0] data_in;
    logic        hold;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_sync;

    modport master (output data_in, hold, input seg, an, frame_sync);
    modport slave  (input data_in, hold, output seg, an, frame_sync);
endinterface

// File: rtl/hex_to_seg.sv
// Combinational 4-bit hex digit to active-low 7-segment pattern.
module hex_to_seg
    import display_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    assign seg_o = hex2seg(nib_i);
endmodule

// File: rtl/output_display_driver.sv
// Time-multiplexed 4-digit hex display of the processor Output bus, latched once per frame.
// Optional leading-zero blanking: define SEG_LZ_BLANK_EN.
module output_display_driver
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic     clk,
    input  logic     reset,
    display_if.slave bus
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLANK_CYCLES + 1);
    localparam logic [PW-1:0] PRE_LAST   = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic          tick;
    state_e        state_q, state_d;
    logic [1:0]    digit_q, digit_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [15:0]   shown_q, shown_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          fs_q, fs_d;
    logic [3:0]    nib;
    logic [6:0]    nib_seg;
    logic          lz;

    assign tick = (pre_q == PRE_LAST);
    assign pre_d = tick ? '0 : pre_q + 1'b1;

    // Outputs are registered, so they are derived from the next-state values
    assign nib = shown_d[{digit_d, 2'b00} +: 4];

    hex_to_seg u_hex (
        .nib_i (nib),
        .seg_o (nib_seg)
    );

`ifdef SEG_LZ_BLANK_EN
    assign lz = ((digit_d == 2'd3) && (shown_d[15:12] == 4'h0)) ||
                ((digit_d == 2'd2) && (shown_d[15:8]  == 8'h00)) ||
                ((digit_d == 2'd1) && (shown_d[15:4]  == 12'h000));
`else
    assign lz = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        bcnt_d  = bcnt_q;
        shown_d = shown_q;
        fs_d    = 1'b0;
        case (state_q)
            BLANK: begin
                if (bcnt_q == BLANK_LAST) begin
                    state_d = SCAN;
                    // digit_q already holds the digit about to be lit
                    if ((digit_q == 2'd0) && !bus.hold) begin
                        shown_d = bus.data_in;
                        fs_d    = 1'b1;
                    end
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            default: begin
                if (tick) begin
                    digit_d = digit_q + 1'b1;
                    bcnt_d  = '0;
                    state_d = BLANK;
                end
            end
        endcase

        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        if (state_d == SCAN) begin
            an_d  = ~(4'b0001 << digit_d);
            seg_d = lz ? SEG_OFF : nib_seg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q   <= '0;
            state_q <= BLANK;
            digit_q <= 2'd0;
            bcnt_q  <= '0;
            shown_q <= 16'h0000;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
            fs_q    <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            state_q <= state_d;
            digit_q <= digit_d;
            bcnt_q  <= bcnt_d;
            shown_q <= shown_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            fs_q    <= fs_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_sync = fs_q;

    // The blank interval always ends well before the prescaler wraps
    assert property (@(posedge clk) disable iff (!reset) !(tick && (state_q == BLANK)));

endmodule

// File: tb/tb_output_display_driver.sv
// Self-checking bench for output_display_driver with REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_output_display_driver;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    display_if dif ();

    output_display_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

`ifdef SEG_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    typedef struct {
        logic [15:0] data;
        logic        hold;
        logic [15:0] shown;
        logic        fs;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[11];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int k);
        logic [15:0] t;
        t = v >> (4 * k);
        if (LZ && (k > 0) && (t == 16'h0)) return 7'h7F;
        return HEX[t[3:0]];
    endfunction

    task automatic push_digit(input logic [15:0] v, input int k);
        exp_t e;
        e.an  = 4'hF ^ (4'h1 << k);
        e.seg = exp_seg(v, k);
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input logic [15:0] v);
        for (int k = 0; k < 4; k++) push_digit(v, k);
    endtask

    task automatic wait_an(input logic [3:0] v, input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((dif.an !== v) && (n < 100));
        checks++;
        if (dif.an !== v) begin
            errors++;
            $display("FAIL %s timeout an=%0h want=%0h", nm, dif.an, v);
        end
    endtask

    // Digit monitor: pops one expectation per lit digit, checks segments and slot timing
    initial begin
        logic [3:0] an_prev;
        logic [6:0] cur_seg;
        int         lit_len;
        int         blank_len;
        bit         run_ok;
        exp_t       e;
        an_prev   = 4'hF;
        cur_seg   = 7'h7F;
        lit_len   = 0;
        blank_len = 0;
        run_ok    = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) run_ok = 1'b0;
            if (dif.an !== an_prev) begin
                if ((an_prev !== 4'hF) && (dif.an === 4'hF)) begin
                    if (mon_en && run_ok) chk("lit_len", 16'(lit_len), 16'd6);
                    blank_len = 1;
                end else if ((an_prev === 4'hF) && (dif.an !== 4'hF)) begin
                    if (mon_en && run_ok) chk("blank_len", 16'(blank_len), 16'd2);
                    if (mon_en) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL sb_empty an=%0h seg=%0h", dif.an, dif.seg);
                            run_ok = 1'b0;
                        end else begin
                            e = exp_q.pop_front();
                            chk("digit_an", 16'(dif.an), 16'(e.an));
                            cur_seg = e.seg;
                            run_ok  = 1'b1;
                        end
                    end
                    lit_len = 1;
                end else begin
                    if (mon_en) chk("no_blank_between", 16'(dif.an), 16'hF);
                    run_ok = 1'b0;
                end
            end else if (dif.an === 4'hF) begin
                blank_len++;
            end else begin
                lit_len++;
            end
            if (mon_en && run_ok && (dif.an !== 4'hF)) chk("digit_seg", 16'(dif.seg), 16'(cur_seg));
            an_prev = dif.an;
        end
    end

    initial begin
        tbl[0]  = '{data: 16'h1A2F, hold: 1'b0, shown: 16'h1A2F, fs: 1'b1};
        tbl[1]  = '{data: 16'hBEEF, hold: 1'b1, shown: 16'h1A2F, fs: 1'b0};
        tbl[2]  = '{data: 16'hBEEF, hold: 1'b0, shown: 16'hBEEF, fs: 1'b1};
        tbl[3]  = '{data: 16'h0005, hold: 1'b0, shown: 16'h0005, fs: 1'b1};
        tbl[4]  = '{data: 16'h0000, hold: 1'b0, shown: 16'h0000, fs: 1'b1};
        tbl[5]  = '{data: 16'h0340, hold: 1'b0, shown: 16'h0340, fs: 1'b1};
        tbl[6]  = '{data: 16'h8091, hold: 1'b0, shown: 16'h8091, fs: 1'b1};
        tbl[7]  = '{data: 16'h6C7D, hold: 1'b0, shown: 16'h6C7D, fs: 1'b1};
        tbl[8]  = '{data: 16'h1234, hold: 1'b1, shown: 16'h6C7D, fs: 1'b0};
        tbl[9]  = '{data: 16'h0EA0, hold: 1'b0, shown: 16'h0EA0, fs: 1'b1};
        tbl[10] = '{data: 16'h1A2F, hold: 1'b0, shown: 16'h1A2F, fs: 1'b1};

        reset       = 1'b0;
        dif.data_in = 16'h0000;
        dif.hold    = 1'b0;

        repeat (5) begin
            @(negedge clk);
            chk("rst_seg", 16'(dif.seg), 16'h7F);
            chk("rst_an", 16'(dif.an), 16'hF);
            chk("rst_fs", 16'(dif.frame_sync), 16'h0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_an", 16'(dif.an), 16'hF);
        chk("post_rst_seg", 16'(dif.seg), 16'h7F);
        @(negedge clk);
        chk("first_scan_an", 16'(dif.an), 16'hE);
        chk("first_scan_seg", 16'(dif.seg), 16'h40);
        chk("first_scan_fs", 16'(dif.frame_sync), 16'h1);
        for (int k = 1; k < 4; k++) push_digit(16'h0000, k);
        @(posedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        chk("fs_width", 16'(dif.frame_sync), 16'h0);

        foreach (tbl[i]) begin
            wait_an(4'h7, "tbl_digit3");
            dif.data_in = tbl[i].data;
            dif.hold    = tbl[i].hold;
            push_frame(tbl[i].shown);
            wait_an(4'hE, "tbl_digit0");
            chk("tbl_fs", 16'(dif.frame_sync), 16'(tbl[i].fs));
        end

        // New data while digit 2 of the 1A2F frame is lit
        wait_an(4'hB, "mid_digit2");
        dif.data_in = 16'h00FF;
        wait_an(4'h7, "mid_digit3");
        push_frame(16'h00FF);
        wait_an(4'hE, "mid_next_frame");
        chk("mid_fs", 16'(dif.frame_sync), 16'h1);
        wait_an(4'h7, "mid_end");
        @(posedge clk);
        mon_en = 1'b0;
        chk("sb_drained", 16'(exp_q.size()), 16'h0);

        // Asynchronous reset between clock edges while a digit is lit
        wait_an(4'hD, "arst_lit");
        dif.data_in = 16'h0000;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_an", 16'(dif.an), 16'hF);
        chk("arst_seg", 16'(dif.seg), 16'h7F);
        chk("arst_fs", 16'(dif.frame_sync), 16'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("restart_blank", 16'(dif.an), 16'hF);
        @(negedge clk);
        chk("restart_an", 16'(dif.an), 16'hE);
        chk("restart_seg", 16'(dif.seg), 16'h40);
        chk("restart_fs", 16'(dif.frame_sync), 16'h1);
        for (int k = 1; k < 4; k++) push_digit(16'h0000, k);
        @(posedge clk);
        mon_en = 1'b1;
        wait_an(4'h7, "restart_digit3");
        @(posedge clk);
        mon_en = 1'b0;
        chk("restart_drained", 16'(exp_q.size()), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
